// File: rtl/cache_tagv_ram_sweep.sv
// Tag/valid store for the L1 caches: one write/read port, one read-only port,
// per-port tag compare, and a one-entry-per-cycle clear sweep after reset or flush.
module cache_tagv_ram_sweep #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 24,
  parameter int READ_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] a_2,
  input  logic [DATA_W-1:0] d,
  input  logic              we,
  input  logic              flush,
  input  logic [DATA_W-2:0] cmp_tag,
  input  logic [DATA_W-2:0] cmp_tag_2,
  output logic              busy,
  output logic [DATA_W-1:0] spo,
  output logic [DATA_W-1:0] spo_2,
  output logic              hit,
  output logic              hit_2
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sweep_we, user_we;
  logic [ADDR_W-1:0] rd_a, rd_a_2;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    user_we  = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        user_we = we;
        if (flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // No reset on the array itself so it can map onto distributed RAM; the sweep clears it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweep_we)     mem[cnt_q] <= '0;
      else if (user_we) mem[a]     <= d;
    end
  end

  if (READ_DELAY != 0) begin : g_reg_addr
    logic [ADDR_W-1:0] a_d_q, a_2_d_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_d_q   <= '0;
        a_2_d_q <= '0;
      end else begin
        a_d_q   <= a;
        a_2_d_q <= a_2;
      end
    end
    assign rd_a   = a_d_q;
    assign rd_a_2 = a_2_d_q;
  end else begin : g_async_addr
    assign rd_a   = a;
    assign rd_a_2 = a_2;
  end

  assign busy  = !rst_n || (state_q == SWEEP);
  assign spo   = busy ? '0 : mem[rd_a];
  assign spo_2 = busy ? '0 : mem[rd_a_2];
  assign hit   = !busy && spo[DATA_W-1]   && (spo[DATA_W-2:0]   == cmp_tag);
  assign hit_2 = !busy && spo_2[DATA_W-1] && (spo_2[DATA_W-2:0] == cmp_tag_2);

endmodule

// File: tb/tb_cache_tagv_ram_sweep.sv
// Bench for cache_tagv_ram_sweep: default-parameter instance plus a small
// asynchronous-read instance, both compared every cycle against an array model.
module tb_cache_tagv_ram_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  a, a_2;
  logic [23:0] d;
  logic        we, flush;
  logic [22:0] cmp_tag, cmp_tag_2;
  logic        busy1, hit1, hit1_2;
  logic [23:0] spo1, spo1_2;

  logic [2:0]  b_a, b_a_2;
  logic [9:0]  b_d;
  logic        b_we, b_flush;
  logic [8:0]  b_cmp, b_cmp_2;
  logic        busy2, hit2, hit2_2;
  logic [9:0]  spo2, spo2_2;

  cache_tagv_ram_sweep #(.ADDR_W(5), .DATA_W(24), .READ_DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .a_2(a_2), .d(d), .we(we), .flush(flush),
    .cmp_tag(cmp_tag), .cmp_tag_2(cmp_tag_2), .busy(busy1), .spo(spo1),
    .spo_2(spo1_2), .hit(hit1), .hit_2(hit1_2));

  cache_tagv_ram_sweep #(.ADDR_W(3), .DATA_W(10), .READ_DELAY(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(b_a), .a_2(b_a_2), .d(b_d), .we(b_we), .flush(b_flush),
    .cmp_tag(b_cmp), .cmp_tag_2(b_cmp_2), .busy(busy2), .spo(spo2),
    .spo_2(spo2_2), .hit(hit2), .hit_2(hit2_2));

  int nchk = 0;
  int npass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: entries still to clear count down; clearing goes index 0 upward.
  logic [23:0] m1 [32];
  int          clr1 = 0;
  logic [4:0]  ad1 = '0, a2d1 = '0;
  logic [9:0]  m2 [8];
  int          clr2 = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      clr1 = 32; ad1 = '0; a2d1 = '0;
      clr2 = 8;
    end else begin
      ad1 = a; a2d1 = a_2;
      if (clr1 > 0) begin
        m1[32 - clr1] = '0;
        clr1--;
      end else begin
        if (we) m1[a] = d;
        if (flush) clr1 = 32;
      end
      if (clr2 > 0) begin
        m2[8 - clr2] = '0;
        clr2--;
      end else begin
        if (b_we) m2[b_a] = b_d;
        if (b_flush) clr2 = 8;
      end
    end
  end

  logic        eb1, eb2;
  logic [23:0] e1, e1_2;
  logic [9:0]  e2, e2_2;

  always @(negedge clk) begin
    if (chk_en) begin
      eb1  = !rst_n || clr1 > 0;
      e1   = eb1 ? 24'h0 : m1[ad1];
      e1_2 = eb1 ? 24'h0 : m1[a2d1];
      chk("busy", {31'b0, busy1}, {31'b0, eb1});
      chk("spo", {8'b0, spo1}, {8'b0, e1});
      chk("spo_2", {8'b0, spo1_2}, {8'b0, e1_2});
      chk("hit", {31'b0, hit1}, {31'b0, !eb1 && e1[23] && e1[22:0] == cmp_tag});
      chk("hit_2", {31'b0, hit1_2}, {31'b0, !eb1 && e1_2[23] && e1_2[22:0] == cmp_tag_2});
      eb2  = !rst_n || clr2 > 0;
      e2   = eb2 ? 10'h0 : m2[b_a];
      e2_2 = eb2 ? 10'h0 : m2[b_a_2];
      chk("b_busy", {31'b0, busy2}, {31'b0, eb2});
      chk("b_spo", {22'b0, spo2}, {22'b0, e2});
      chk("b_spo_2", {22'b0, spo2_2}, {22'b0, e2_2});
      chk("b_hit", {31'b0, hit2}, {31'b0, !eb2 && e2[9] && e2[8:0] == b_cmp});
      chk("b_hit_2", {31'b0, hit2_2}, {31'b0, !eb2 && e2_2[9] && e2_2[8:0] == b_cmp_2});
    end
  end

  // Length of the most recent busy run that started after rst_n was high.
  int run1 = 0, last1 = 0, run2 = 0, last2 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run1 = 0; run2 = 0;
    end else begin
      if (busy1) run1++;
      else if (run1 != 0) begin last1 = run1; run1 = 0; end
      if (busy2) run2++;
      else if (run2 != 0) begin last2 = run2; run2 = 0; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy1 || busy2) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", n, (n < 200) ? n : 0);
    @(negedge clk);
    #1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      a = 5'(i); a_2 = 5'(31 - i); b_a = 3'(i); b_a_2 = 3'(7 - i);
      tick();
    end
  endtask

  task automatic rand_cycle();
    we = 1'($urandom_range(0, 1));
    a = 5'($urandom); a_2 = 5'($urandom);
    d = 24'($urandom_range(0, 3)); d[23] = 1'($urandom_range(0, 1));
    cmp_tag = 23'($urandom_range(0, 3)); cmp_tag_2 = 23'($urandom_range(0, 3));
    flush = ($urandom_range(0, 39) == 0);
    b_we = 1'($urandom_range(0, 1));
    b_a = 3'($urandom); b_a_2 = 3'($urandom);
    b_d = 10'($urandom_range(0, 3)); b_d[9] = 1'($urandom_range(0, 1));
    b_cmp = 9'($urandom_range(0, 3)); b_cmp_2 = 9'($urandom_range(0, 3));
    b_flush = ($urandom_range(0, 39) == 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; a = '0; a_2 = '0; d = '0; we = 1'b0; flush = 1'b0;
    cmp_tag = '0; cmp_tag_2 = '0;
    b_a = '0; b_a_2 = '0; b_d = '0; b_we = 1'b0; b_flush = 1'b0; b_cmp = '0; b_cmp_2 = '0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    wait_idle();
    chk("init_busy_len", last1, 32);
    chk("b_init_busy_len", last2, 8);
    read_all();
    @(negedge clk);
    chk("init_read_zero", {8'b0, spo1}, 32'h0);

    tick();
    we = 1'b1; a = 5'd5; d = 24'h80_1234;
    tick();
    we = 1'b0; cmp_tag = 23'h1234;
    @(negedge clk);
    chk("wr5_spo", {8'b0, spo1}, 32'h0080_1234);
    chk("wr5_hit", {31'b0, hit1}, 32'h1);
    #1 cmp_tag = 23'h1235;
    @(negedge clk);
    chk("wr5_miss", {31'b0, hit1}, 32'h0);

    tick();
    we = 1'b1; a = 5'd7; d = 24'h80_0777;
    tick();
    a = 5'd9; d = 24'h80_0999;
    tick();
    we = 1'b0; a = 5'd7; a_2 = 5'd9;
    tick();
    @(negedge clk);
    chk("dual_spo", {8'b0, spo1}, 32'h0080_0777);
    chk("dual_spo_2", {8'b0, spo1_2}, 32'h0080_0999);
    #1 a_2 = 5'd7;
    tick();
    @(negedge clk);
    chk("same_idx_spo_2", {8'b0, spo1_2}, 32'h0080_0777);

    tick();
    b_we = 1'b1; b_a = 3'd2; b_d = 10'h3FF; b_cmp = 9'h1FF;
    tick();
    b_we = 1'b0;
    @(negedge clk);
    chk("b_async_spo", {22'b0, spo2}, 32'h3FF);
    chk("b_async_hit", {31'b0, hit2}, 32'h1);

    tick();
    for (int i = 0; i < 400; i++) rand_cycle();
    we = 1'b0; flush = 1'b0; b_we = 1'b0; b_flush = 1'b0;
    wait_idle();

    tick();
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; a = 5'(i); d = {1'b1, 23'(i)};
      tick();
    end
    we = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; we = 1'b1; a = 5'd3; d = 24'hFF_FFFF;
    tick();
    we = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();
    chk("flush_busy_len", last1, 32);
    a = 5'd3;
    tick();
    @(negedge clk);
    chk("dropped_wr3", {8'b0, spo1}, 32'h0);
    tick();
    read_all();

    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_idle();
    chk("rst_mid_busy_len", last1, 32);
    chk("b_rst_busy_len", last2, 8);
    read_all();
    for (int i = 0; i < 100; i++) rand_cycle();
    we = 1'b0; flush = 1'b0; b_we = 1'b0; b_flush = 1'b0;
    wait_idle();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
